// File: rtl/layer_arb_pkg.sv
// Shared types and constants for the layer priority arbiter.
package layer_arb_pkg;

  localparam int unsigned NUM_LAYERS_DEFAULT   = 4;
  localparam int unsigned BLINK_FRAMES_DEFAULT = 16;
  localparam int unsigned LAYER_IDX_W          = $clog2(NUM_LAYERS_DEFAULT);

  typedef logic [LAYER_IDX_W-1:0] rank_t;
  typedef logic [LAYER_IDX_W-1:0] layer_idx_t;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } cfg_state_t;

  // activeLayer code reported when no layer wins the pixel
  localparam logic [LAYER_IDX_W:0] BACKGROUND_IDX = {1'b1, LAYER_IDX_W'(0)};

endpackage

// File: rtl/layer_priority_arbiter_select.sv
// Combinational winner search: lowest rank wins, equal ranks go to the lower layer index.
module layer_rank_select
  import layer_arb_pkg::*;
#(
  parameter int unsigned NUM_LAYERS = NUM_LAYERS_DEFAULT,
  parameter int unsigned IDX_W      = $clog2(NUM_LAYERS_DEFAULT)
) (
  input  logic [NUM_LAYERS-1:0]            eff_req,
  input  logic [NUM_LAYERS-1:0][IDX_W-1:0] rank,
  output logic [IDX_W-1:0]                 winner_c,
  output logic                             valid_c,
  output logic                             collision_c
);

  logic             found;
  logic [IDX_W-1:0] best_rank;

  // Ascending scan with strict compare keeps the lower index on rank ties
  always_comb begin
    found     = 1'b0;
    best_rank = '0;
    winner_c  = '0;
    for (int i = 0; i < int'(NUM_LAYERS); i++) begin
      if (eff_req[i] && (!found || (rank[i] < best_rank))) begin
        found     = 1'b1;
        best_rank = rank[i];
        winner_c  = IDX_W'(i);
      end
    end
    valid_c = found;
  end

  // Clearing the lowest set bit leaves something only if two or more bits were set
  assign collision_c = |(eff_req & (eff_req - NUM_LAYERS'(1)));

endmodule

// File: rtl/layer_priority_arbiter.sv
// Registered per-pixel layer arbiter with frame-synchronous rank reprogramming.
// Optional per-layer blinking is built when LAYER_BLINK_EN is defined.
module layer_priority_arbiter
  import layer_arb_pkg::*;
#(
  parameter int unsigned NUM_LAYERS   = NUM_LAYERS_DEFAULT,
  parameter int unsigned BLINK_FRAMES = BLINK_FRAMES_DEFAULT
) (
  input  logic                          clk,
  input  logic                          resetN,
  input  logic                          startOfFrame,
  input  logic [NUM_LAYERS-1:0]         drawReq,
  input  logic [8*NUM_LAYERS-1:0]       layerRGB,
  input  logic [7:0]                    backGroundRGB,
  input  logic                          cfgValid,
  input  logic [$clog2(NUM_LAYERS)-1:0] cfgLayer,
  input  logic [$clog2(NUM_LAYERS)-1:0] cfgRank,
  input  logic                          cfgBlink,
  input  logic                          cfgCommit,
  output logic                          cfgReady,
  output logic [7:0]                    pixelRGB,
  output logic [$clog2(NUM_LAYERS):0]   activeLayer,
  output logic                          collision
);

  localparam int unsigned IDX_W = $clog2(NUM_LAYERS);
  localparam logic [IDX_W:0] BG_IDX = {1'b1, IDX_W'(0)};

  cfg_state_t state_q, state_d;
  logic       ready_d;

  logic [NUM_LAYERS-1:0][IDX_W-1:0] active_rank, shadow_rank;
  logic [NUM_LAYERS-1:0]            eff_req;
  logic [IDX_W-1:0]                 winner_c;
  logic                             win_valid_c;
  logic                             collision_c;
  logic                             cfg_accept_c, cfg_write_c, copy_c;

  assign cfg_accept_c = (state_q == IDLE);
  assign cfg_write_c  = cfg_accept_c && cfgValid && (32'(cfgLayer) < NUM_LAYERS);
  assign copy_c       = (state_q == PENDING) && startOfFrame;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // A commit arriving with startOfFrame only arms; the copy needs a later pulse
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cfgCommit)    state_d = PENDING;
      PENDING: if (startOfFrame) state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_d = 1'b0;
    if (state_d == IDLE) ready_d = 1'b1;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) cfgReady <= 1'b1;
    else         cfgReady <= ready_d;
  end

  // Shadow table takes writes; active table only changes on an applying frame start
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < int'(NUM_LAYERS); i++) begin
        shadow_rank[i] <= IDX_W'(i);
        active_rank[i] <= IDX_W'(i);
      end
    end else begin
      if (cfg_write_c) shadow_rank[cfgLayer] <= cfgRank;
      if (copy_c)      active_rank <= shadow_rank;
    end
  end

`ifdef LAYER_BLINK_EN
  localparam int unsigned FRAME_W = $clog2(BLINK_FRAMES);

  logic [FRAME_W-1:0]    frame_cnt;
  logic                  blink_phase;
  logic [NUM_LAYERS-1:0] shadow_blink, active_blink;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (startOfFrame) begin
      if (frame_cnt == FRAME_W'(BLINK_FRAMES - 1)) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + FRAME_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      shadow_blink <= '0;
      active_blink <= '0;
    end else begin
      if (cfg_write_c) shadow_blink[cfgLayer] <= cfgBlink;
      if (copy_c)      active_blink <= shadow_blink;
    end
  end

  // Blinked-off layers drop out of both arbitration and collision detection
  assign eff_req = drawReq & ~(active_blink & {NUM_LAYERS{blink_phase}});
`else
  logic unused_blink_cfg;
  assign unused_blink_cfg = cfgBlink ^ 1'(BLINK_FRAMES);
  assign eff_req          = drawReq;
`endif

  layer_rank_select #(
    .NUM_LAYERS (NUM_LAYERS),
    .IDX_W      (IDX_W)
  ) u_select (
    .eff_req     (eff_req),
    .rank        (active_rank),
    .winner_c    (winner_c),
    .valid_c     (win_valid_c),
    .collision_c (collision_c)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pixelRGB    <= 8'h00;
      activeLayer <= BG_IDX;
      collision   <= 1'b0;
    end else begin
      if (win_valid_c) begin
        pixelRGB    <= layerRGB[{winner_c, 3'b000} +: 8];
        activeLayer <= {1'b0, winner_c};
      end else begin
        pixelRGB    <= backGroundRGB;
        activeLayer <= BG_IDX;
      end
      collision <= collision_c;
    end
  end

endmodule

// File: tb/tb_layer_priority_arbiter.sv
// Self-checking bench for layer_priority_arbiter: reference model plus expectation queue.
module tb_layer_priority_arbiter;
  import layer_arb_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 2;
  localparam int unsigned BF = 2;

  logic           clk = 1'b0;
  logic           resetN;
  logic           startOfFrame;
  logic [N-1:0]   drawReq;
  logic [8*N-1:0] layerRGB;
  logic [7:0]     backGroundRGB;
  logic           cfgValid;
  logic [W-1:0]   cfgLayer;
  logic [W-1:0]   cfgRank;
  logic           cfgBlink;
  logic           cfgCommit;
  logic           cfgReady;
  logic [7:0]     pixelRGB;
  logic [W:0]     activeLayer;
  logic           collision;

  layer_priority_arbiter #(.NUM_LAYERS(N), .BLINK_FRAMES(BF)) dut (
    .clk           (clk),
    .resetN        (resetN),
    .startOfFrame  (startOfFrame),
    .drawReq       (drawReq),
    .layerRGB      (layerRGB),
    .backGroundRGB (backGroundRGB),
    .cfgValid      (cfgValid),
    .cfgLayer      (cfgLayer),
    .cfgRank       (cfgRank),
    .cfgBlink      (cfgBlink),
    .cfgCommit     (cfgCommit),
    .cfgReady      (cfgReady),
    .pixelRGB      (pixelRGB),
    .activeLayer   (activeLayer),
    .collision     (collision)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] rgb;
    logic [W:0] idx;
    logic       col;
    int         due;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cycle    = 0;

  // Reference state
  logic [W-1:0] m_rank[N];
  logic [W-1:0] m_shadow[N];
  logic [N-1:0] m_blink, m_shadow_blink;
  logic         m_pending;
  logic         m_phase;
  int           m_fcnt;

  // layer0=AA layer1=E0 layer2=03 layer3=55
  localparam logic [8*N-1:0] RGB_A = {8'h55, 8'h03, 8'hE0, 8'hAA};

  always @(posedge clk) cycle <= cycle + 1;

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cycle) begin
      e = sb.pop_front();
      n_checks++;
      if (e.due != cycle)
        $display("FAIL pixel_stale due=%0d now=%0d", e.due, cycle);
      else if ({pixelRGB, activeLayer, collision} !== {e.rgb, e.idx, e.col})
        $display("FAIL pixel_out cyc=%0d got rgb=%h idx=%b col=%b want rgb=%h idx=%b col=%b",
                 cycle, pixelRGB, activeLayer, collision, e.rgb, e.idx, e.col);
      else
        n_pass++;
    end
  end

  task automatic model_reset();
    for (int i = 0; i < int'(N); i++) begin
      m_rank[i]   = W'(i);
      m_shadow[i] = W'(i);
    end
    m_blink        = '0;
    m_shadow_blink = '0;
    m_pending      = 1'b0;
    m_phase        = 1'b0;
    m_fcnt         = 0;
  endtask

  // Rank-major search: first rank value that has a requester, lowest index within it
  function automatic exp_t model_px(input logic [N-1:0] req, input logic [8*N-1:0] rgb,
                                    input logic [7:0] bg);
    exp_t         e;
    logic [N-1:0] eff;
    bit           found;
    eff   = m_phase ? (req & ~m_blink) : req;
    found = 0;
    e.rgb = bg;
    e.idx = BACKGROUND_IDX;
    e.col = ($countones(eff) >= 2);
    e.due = 0;
    for (int r = 0; r < int'(N); r++)
      for (int i = 0; i < int'(N); i++)
        if (!found && eff[i] && (int'(m_rank[i]) == r)) begin
          found = 1;
          e.rgb = rgb[8*i +: 8];
          e.idx = {1'b0, W'(i)};
        end
    return e;
  endfunction

  task automatic step(input logic [N-1:0] req, input logic [8*N-1:0] rgb, input logic [7:0] bg,
                      input logic sof, input logic valid, input int layer, input int rank,
                      input logic blink, input logic commit);
    exp_t e;
    drawReq = req; layerRGB = rgb; backGroundRGB = bg; startOfFrame = sof;
    cfgValid = valid; cfgLayer = W'(layer); cfgRank = W'(rank); cfgBlink = blink;
    cfgCommit = commit;
    e     = model_px(req, rgb, bg);
    e.due = cycle + 1;
    sb.push_back(e);
    if (!m_pending && valid) begin
      m_shadow[layer] = W'(rank);
`ifdef LAYER_BLINK_EN
      m_shadow_blink[layer] = blink;
`endif
    end
    if (m_pending && sof) begin
      m_rank    = m_shadow;
      m_blink   = m_shadow_blink;
      m_pending = 1'b0;
    end else if (!m_pending && commit) begin
      m_pending = 1'b1;
    end
`ifdef LAYER_BLINK_EN
    if (sof) begin
      if (m_fcnt == int'(BF) - 1) begin
        m_fcnt  = 0;
        m_phase = ~m_phase;
      end else begin
        m_fcnt++;
      end
    end
`endif
    @(negedge clk);
    startOfFrame = 1'b0; cfgValid = 1'b0; cfgCommit = 1'b0;
  endtask

  task automatic px(input logic [N-1:0] req, input logic [8*N-1:0] rgb, input logic [7:0] bg,
                    input logic sof);
    step(req, rgb, bg, sof, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic cfg(input int layer, input int rank, input logic blink);
    step(drawReq, layerRGB, backGroundRGB, 1'b0, 1'b1, layer, rank, blink, 1'b0);
  endtask

  task automatic commit(input logic sof);
    step(drawReq, layerRGB, backGroundRGB, sof, 1'b0, 0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    resetN = 1'b0; startOfFrame = 0; drawReq = '0; layerRGB = '0; backGroundRGB = '0;
    cfgValid = 0; cfgLayer = '0; cfgRank = '0; cfgBlink = 0; cfgCommit = 0;
    model_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (pixelRGB !== 8'h00) $display("FAIL reset_rgb got %h want 00", pixelRGB); else n_pass++;
    n_checks++; if (activeLayer !== 3'b100) $display("FAIL reset_idx got %b want 100", activeLayer); else n_pass++;
    n_checks++; if (collision !== 1'b0) $display("FAIL reset_col got %b want 0", collision); else n_pass++;
    n_checks++; if (cfgReady !== 1'b1) $display("FAIL reset_ready got %b want 1", cfgReady); else n_pass++;
    resetN = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_background();
    px(4'b0000, RGB_A, 8'h1C, 1'b0);
    n_checks++;
    if ({pixelRGB, activeLayer, collision} !== {8'h1C, 3'b100, 1'b0})
      $display("FAIL background got %h/%b/%b want 1c/100/0", pixelRGB, activeLayer, collision);
    else n_pass++;
  endtask

  task automatic test_default_ranks();
    px(4'b0110, RGB_A, 8'h1C, 1'b0);
    n_checks++;
    if ({pixelRGB, activeLayer, collision} !== {8'hE0, 3'b001, 1'b1})
      $display("FAIL default_0110 got %h/%b/%b want e0/001/1", pixelRGB, activeLayer, collision);
    else n_pass++;
    for (int k = 0; k < 16; k++)
      px(N'($urandom_range(0, 15)), {$urandom, 8'h00} >> 8, 8'($urandom), 1'b0);
  endtask

  task automatic test_commit_midframe();
    n_checks++; if (cfgReady !== 1'b1) $display("FAIL mid_ready_idle got %b want 1", cfgReady); else n_pass++;
    cfg(2, 0, 1'b0);
    cfg(1, 2, 1'b0);
    commit(1'b0);
    n_checks++; if (cfgReady !== 1'b0) $display("FAIL mid_ready_pending got %b want 0", cfgReady); else n_pass++;
    cfg(0, 3, 1'b0);
    n_checks++; if (cfgReady !== 1'b0) $display("FAIL mid_ready_hold got %b want 0", cfgReady); else n_pass++;
    px(4'b0110, RGB_A, 8'h1C, 1'b0);
    n_checks++; if (pixelRGB !== 8'hE0) $display("FAIL mid_before_sof got %h want e0", pixelRGB); else n_pass++;
    px(4'b0110, RGB_A, 8'h1C, 1'b1);
    n_checks++; if (cfgReady !== 1'b1) $display("FAIL mid_ready_after got %b want 1", cfgReady); else n_pass++;
    px(4'b0110, RGB_A, 8'h1C, 1'b0);
    n_checks++;
    if ({pixelRGB, activeLayer} !== {8'h03, 3'b010})
      $display("FAIL mid_after_sof got %h/%b want 03/010", pixelRGB, activeLayer);
    else n_pass++;
  endtask

  task automatic test_commit_with_sof();
    cfg(3, 0, 1'b0);
    commit(1'b1);
    n_checks++; if (cfgReady !== 1'b0) $display("FAIL csof_ready got %b want 0", cfgReady); else n_pass++;
    px(4'b1010, RGB_A, 8'h1C, 1'b0);
    n_checks++; if (pixelRGB !== 8'hE0) $display("FAIL csof_not_applied got %h want e0", pixelRGB); else n_pass++;
    px(4'b1010, RGB_A, 8'h1C, 1'b1);
    px(4'b1010, RGB_A, 8'h1C, 1'b0);
    n_checks++; if (pixelRGB !== 8'h55) $display("FAIL csof_applied got %h want 55", pixelRGB); else n_pass++;
  endtask

  task automatic test_duplicate_ranks();
    px(4'b1001, RGB_A, 8'h1C, 1'b0);
    n_checks++;
    if ({pixelRGB, activeLayer, collision} !== {8'hAA, 3'b000, 1'b1})
      $display("FAIL dup_1001 got %h/%b/%b want aa/000/1", pixelRGB, activeLayer, collision);
    else n_pass++;
    px(4'b1100, RGB_A, 8'h1C, 1'b0);
    n_checks++; if (activeLayer !== 3'b010) $display("FAIL dup_1100 got %b want 010", activeLayer); else n_pass++;
    px(4'b1111, RGB_A, 8'h1C, 1'b0);
  endtask

  task automatic test_random_ranks();
    for (int round = 0; round < 4; round++) begin
      for (int l = 0; l < int'(N); l++) cfg(l, int'($urandom_range(0, N - 1)), 1'b0);
      commit(1'b0);
      for (int k = 0; k < 3; k++) px(N'($urandom_range(0, 15)), {$urandom}, 8'($urandom), 1'b0);
      px(N'($urandom_range(0, 15)), {$urandom}, 8'($urandom), 1'b1);
      for (int k = 0; k < 6; k++) px(N'($urandom_range(0, 15)), {$urandom}, 8'($urandom), 1'b0);
    end
  endtask

  task automatic test_reset_pending();
    cfg(0, 3, 1'b0);
    cfg(1, 0, 1'b0);
    commit(1'b0);
    n_checks++; if (cfgReady !== 1'b0) $display("FAIL rstp_pending got %b want 0", cfgReady); else n_pass++;
    @(negedge clk);
    resetN = 1'b0;
    model_reset();
    @(negedge clk);
    n_checks++; if (cfgReady !== 1'b1) $display("FAIL rstp_ready got %b want 1", cfgReady); else n_pass++;
    resetN = 1'b1;
    @(negedge clk);
    px(4'b0011, RGB_A, 8'h1C, 1'b1);
    px(4'b0011, RGB_A, 8'h1C, 1'b0);
    n_checks++; if (pixelRGB !== 8'hAA) $display("FAIL rstp_discarded got %h want aa", pixelRGB); else n_pass++;
  endtask

`ifdef LAYER_BLINK_EN
  task automatic test_blink();
    cfg(0, 0, 1'b1);
    commit(1'b0);
    px(4'b0001, RGB_A, 8'h1C, 1'b1);
    for (int f = 0; f < 8; f++) begin
      px(4'b0001, RGB_A, 8'h1C, 1'b1);
      px(4'b0001, RGB_A, 8'h1C, 1'b0);
      px(4'b0011, RGB_A, 8'h1C, 1'b0);
      px(4'b0001, RGB_A, 8'h1C, 1'b0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_background();
    test_default_ranks();
    test_commit_midframe();
    test_commit_with_sof();
    test_duplicate_ranks();
    test_random_ranks();
    test_reset_pending();
`ifdef LAYER_BLINK_EN
    test_blink();
`endif
    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain got %0d entries want 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
